// File: rtl/invsqrt_out_fifo.sv
// rtl/invsqrt_out_fifo.sv - show-ahead output FIFO for the inverse-square-root result stream
module invsqrt_out_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic [WIDTH-1:0]           DataIn,
    input  logic                       DataInValid,
    input  logic                       Flush,
    output logic [WIDTH-1:0]           DataOut,
    output logic                       DataValid,
    input  logic                       DataReady,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Overflow,
    output logic [15:0]                DropCnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             overflow_q;
    logic [15:0]      drop_cnt_q;

    logic wr_req;
    logic rd_en;
    logic full;
    logic wr_en;
    logic drop;

    always_comb begin
        full   = (count_q == FULL_COUNT);
        wr_req = DataInValid && ce && !Flush;
        rd_en  = (count_q != '0) && DataReady && !Flush;
        // A read in the same cycle frees the slot the incoming word needs.
        wr_en  = wr_req && (!full || rd_en);
        drop   = wr_req && full && !rd_en;
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr] <= DataIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (Flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count_q <= count_q + 1'b1;
            end else if (rd_en && !wr_en) begin
                count_q <= count_q - 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end
        end
    end

    assign DataOut   = mem[rd_ptr];
    assign DataValid = (count_q != '0);
    assign Count     = count_q;
    assign Overflow  = overflow_q;
    assign DropCnt   = drop_cnt_q;
endmodule

// File: tb/tb_invsqrt_out_fifo.sv
// tb/tb_invsqrt_out_fifo.sv - scoreboard bench for invsqrt_out_fifo
module tb_invsqrt_out_fifo;
    logic        clk;
    logic        rst;
    logic        ce;
    logic [31:0] din;
    logic        din_valid;
    logic        flush;
    logic [31:0] dout;
    logic        dvalid;
    logic        ready;
    logic [4:0]  count;
    logic        ovf;
    logic [15:0] dropcnt;

    logic [31:0] q[$];
    int          mdrops;
    logic        movf;
    int          checks;
    int          errors;

    invsqrt_out_fifo #(.WIDTH(32), .DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .DataIn     (din),
        .DataInValid(din_valid),
        .Flush      (flush),
        .DataOut    (dout),
        .DataValid  (dvalid),
        .DataReady  (ready),
        .Count      (count),
        .Overflow   (ovf),
        .DropCnt    (dropcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model from the driven inputs, pop/compare reads, then check state.
    task automatic cycle();
        logic        full;
        logic        rd;
        logic        wrq;
        logic [31:0] exp;
        if (rst) begin
            q.delete();
            mdrops = 0;
            movf   = 1'b0;
        end else if (flush) begin
            q.delete();
        end else begin
            full = (q.size() == 16);
            rd   = (q.size() > 0) && ready;
            wrq  = din_valid && ce;
            if (rd) begin
                exp = q.pop_front();
                check("read_data", dout, exp);
            end
            if (wrq) begin
                if (!full || rd) begin
                    q.push_back(din);
                end else begin
                    movf = 1'b1;
                    if (mdrops != 65535) mdrops++;
                end
            end
        end
        @(posedge clk);
        #1;
        check("count", 32'(count), 32'(q.size()));
        check("valid", 32'(dvalid), 32'(q.size() != 0));
        check("overflow", 32'(ovf), 32'(movf));
        check("dropcnt", 32'(dropcnt), 32'(mdrops));
        if (q.size() != 0) check("head", dout, q[0]);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        mdrops    = 0;
        movf      = 1'b0;
        rst       = 1'b1;
        ce        = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        flush     = 1'b0;
        ready     = 1'b0;
        cycle();
        check("reset_count", 32'(count), 32'd0);
        check("reset_valid", 32'(dvalid), 32'd0);
        rst = 1'b0;

        // Basic ordered transfer
        ce = 1'b1;
        din_valid = 1'b1;
        din = 32'h3F800000; cycle();
        din = 32'h3F000000; cycle();
        din = 32'h3EB504F3; cycle();
        din_valid = 1'b0;
        check("basic_count", 32'(count), 32'd3);
        check("basic_head", dout, 32'h3F800000);
        ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("basic_drained", 32'(count), 32'd0);
        check("basic_drained_valid", 32'(dvalid), 32'd0);
        ready = 1'b0;

        // ce gating
        ce = 1'b0;
        din_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din = 32'hDEAD0000 + 32'(i);
            cycle();
        end
        check("ce_gate_count", 32'(count), 32'd0);
        check("ce_gate_drops", 32'(dropcnt), 32'd0);

        // Overflow
        ce = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            din = 32'(i);
            cycle();
        end
        din_valid = 1'b0;
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_flag", 32'(ovf), 32'd1);
        check("ovf_drops", 32'(dropcnt), 32'd3);
        check("ovf_head", dout, 32'h00000001);
        ready = 1'b1;
        for (int i = 0; i < 16; i++) cycle();
        ready = 1'b0;

        // Full with concurrent read and write
        din_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = 32'h100 + 32'(i);
            cycle();
        end
        din = 32'hAAAA5555;
        ready = 1'b1;
        cycle();
        din_valid = 1'b0;
        check("full_rw_count", 32'(count), 32'd16);
        check("full_rw_drops", 32'(dropcnt), 32'd3);
        for (int i = 0; i < 15; i++) cycle();
        check("full_rw_last", dout, 32'hAAAA5555);
        cycle();
        ready = 1'b0;

        // Flush with concurrent write
        din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 32'h200 + 32'(i);
            cycle();
        end
        flush = 1'b1;
        din = 32'h2FF;
        cycle();
        flush = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_drops", 32'(dropcnt), 32'd3);
        check("flush_keeps_ovf", 32'(ovf), 32'd1);

        // Wrap then mid-stream reset
        ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = 32'h300 + 32'(i);
            cycle();
        end
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din = 32'h400 + 32'(i);
            cycle();
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        din_valid = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(dvalid), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_drops", 32'(dropcnt), 32'd0);
        din_valid = 1'b1;
        din = 32'h12345678;
        cycle();
        din_valid = 1'b0;
        check("rst_first_word", dout, 32'h12345678);
        ready = 1'b1;
        cycle();
        ready = 1'b0;

        // Random soak
        for (int i = 0; i < 1000; i++) begin
            din       = $urandom;
            din_valid = ($urandom_range(0, 3) != 0);
            ce        = ($urandom_range(0, 4) != 0);
            ready     = ($urandom_range(0, 2) == 0);
            cycle();
        end
        din_valid = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 17; i++) cycle();
        check("soak_empty", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
